alu_execute_control: RTL and testbench

- Control FSM for register-register ALU instructions (ADD, SUB, NOT, AND, OR, XOR, XNOR) on the single shared bus datapath.
- Consumes the FSM_start code produced by the instruction fetch/decode controller (code 4'b0001 = ALU).
- Sequences the register-file, operand-A, ALU and Z-register enables.
- Returns a one-cycle DONE pulse to the fetch controller, which is waiting for DONE before its next fetch.

---
 rtl/alu_execute_control.sv | 137 +++++++++++++
 tb/tb_alu_execute_control.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_execute_control.sv
// Control FSM for register-register ALU instructions on a single shared bus.
// It sequences register-file, operand-A, ALU and Z enables, then returns a one-cycle DONE pulse.
module alu_execute_control #(
  parameter int NUM_REGS = 4,
  parameter int SEL_W = 2,
  parameter logic [3:0] START_CODE = 4'b0001
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [3:0]          FSM_start,
  input  logic [3:0]          opcode,
  input  logic [SEL_W-1:0]    rd_sel,
  input  logic [SEL_W-1:0]    rs_sel,
  input  logic [SEL_W-1:0]    rt_sel,
  output logic [NUM_REGS-1:0] reg_out_en,
  output logic [NUM_REGS-1:0] reg_in_en,
  output logic                A_in_en,
  output logic [2:0]          ALU_op,
  output logic                Z_in_en,
  output logic                Z_out_en,
  output logic                DONE,
  output logic                busy,
  output logic                illegal
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    COMPUTE_B,
    COMPUTE_U,
    WRITE_BACK,
    DONE_ST
  } state_t;

  localparam logic [3:0] OP_NOT = 4'b0011;

  state_t state;
  logic [3:0] op_q;
  logic [SEL_W-1:0] rd_q;
  logic [SEL_W-1:0] rt_q;

  function automatic logic [NUM_REGS-1:0] one_hot(input logic [SEL_W-1:0] sel);
    logic [NUM_REGS-1:0] v;
    v = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op != 4'b0000) && !op[3];
  endfunction

  // 0001..0111 map onto 000..110, so the ALU code is the low bits minus one.
  function automatic logic [2:0] alu_code(input logic [3:0] op);
    return op[2:0] - 3'd1;
  endfunction

  // Outputs are registered alongside the state, so each one reflects the state being entered.
  // rs is consumed at the launch edge itself (LOAD_A outputs), so it needs no holding register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      op_q       <= '0;
      rd_q       <= '0;
      rt_q       <= '0;
      reg_out_en <= '0;
      reg_in_en  <= '0;
      A_in_en    <= 1'b0;
      ALU_op     <= 3'b000;
      Z_in_en    <= 1'b0;
      Z_out_en   <= 1'b0;
      DONE       <= 1'b0;
      busy       <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      reg_out_en <= '0;
      reg_in_en  <= '0;
      A_in_en    <= 1'b0;
      Z_in_en    <= 1'b0;
      Z_out_en   <= 1'b0;
      DONE       <= 1'b0;
      illegal    <= 1'b0;
      busy       <= 1'b1;
      case (state)
        IDLE: begin
          busy   <= 1'b0;
          ALU_op <= 3'b000;
          if (FSM_start == START_CODE) begin
            op_q <= opcode;
            rd_q <= rd_sel;
            rt_q <= rt_sel;
            busy <= 1'b1;
            if (is_alu_op(opcode)) begin
              state      <= LOAD_A;
              reg_out_en <= one_hot(rs_sel);
              A_in_en    <= 1'b1;
              ALU_op     <= alu_code(opcode);
            end else begin
              state   <= DONE_ST;
              DONE    <= 1'b1;
              illegal <= 1'b1;
            end
          end
        end
        LOAD_A: begin
          Z_in_en <= 1'b1;
          if (op_q == OP_NOT) begin
            state <= COMPUTE_U;
          end else begin
            state      <= COMPUTE_B;
            reg_out_en <= one_hot(rt_q);
          end
        end
        COMPUTE_B, COMPUTE_U: begin
          state     <= WRITE_BACK;
          Z_out_en  <= 1'b1;
          reg_in_en <= one_hot(rd_q);
        end
        WRITE_BACK: begin
          state <= DONE_ST;
          DONE  <= 1'b1;
        end
        DONE_ST: begin
          state  <= IDLE;
          busy   <= 1'b0;
          ALU_op <= 3'b000;
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          ALU_op <= 3'b000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_execute_control.sv
// Self-checking bench for alu_execute_control: a fixed cycle table, a trace model of each
// instruction for randomized transactions, and hand sequences for reset, relaunch and input changes.
module tb_alu_execute_control;

  localparam logic [3:0] START = 4'b0001;

  logic clock;
  logic reset;
  logic [3:0] FSM_start;
  logic [3:0] opcode;
  logic [1:0] rd_sel, rs_sel, rt_sel;
  logic [3:0] reg_out_en, reg_in_en;
  logic A_in_en, Z_in_en, Z_out_en, DONE, busy, illegal;
  logic [2:0] ALU_op;

  int checks = 0;
  int failures = 0;

  alu_execute_control #(.NUM_REGS(4), .SEL_W(2), .START_CODE(START)) dut (
    .clock(clock),
    .reset(reset),
    .FSM_start(FSM_start),
    .opcode(opcode),
    .rd_sel(rd_sel),
    .rs_sel(rs_sel),
    .rt_sel(rt_sel),
    .reg_out_en(reg_out_en),
    .reg_in_en(reg_in_en),
    .A_in_en(A_in_en),
    .ALU_op(ALU_op),
    .Z_in_en(Z_in_en),
    .Z_out_en(Z_out_en),
    .DONE(DONE),
    .busy(busy),
    .illegal(illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Output vector layout: {reg_out_en, reg_in_en, A_in_en, ALU_op, Z_in_en, Z_out_en, DONE, busy, illegal}
  function automatic logic [16:0] pk(logic [3:0] roe, logic [3:0] rie, logic a, logic [2:0] alu,
                                     logic zi, logic zo, logic dn, logic bs, logic il);
    return {roe, rie, a, alu, zi, zo, dn, bs, il};
  endfunction

  function automatic logic [16:0] observed();
    return {reg_out_en, reg_in_en, A_in_en, ALU_op, Z_in_en, Z_out_en, DONE, busy, illegal};
  endfunction

  // Expected outputs k cycles after a launch edge, built from the instruction's bus schedule.
  function automatic logic [16:0] model(logic [3:0] op, logic [1:0] rs, logic [1:0] rt,
                                        logic [1:0] rd, int k);
    logic [2:0] alu;
    logic [3:0] src1, src2, dst;
    if (op == 4'd0 || op > 4'd7) return (k == 1) ? pk(4'd0, 4'd0, 0, 3'd0, 0, 0, 1, 1, 1) : 17'd0;
    alu  = 3'(int'(op) - 1);
    src1 = 4'(1 << rs);
    src2 = (op == 4'd3) ? 4'd0 : 4'(1 << rt);
    dst  = 4'(1 << rd);
    case (k)
      1: return pk(src1, 4'd0, 1, alu, 0, 0, 0, 1, 0);
      2: return pk(src2, 4'd0, 0, alu, 1, 0, 0, 1, 0);
      3: return pk(4'd0, dst, 0, alu, 0, 1, 0, 1, 0);
      4: return pk(4'd0, 4'd0, 0, alu, 0, 0, 1, 1, 0);
      default: return 17'd0;
    endcase
  endfunction

  function automatic int txn_len(logic [3:0] op);
    return (op == 4'd0 || op > 4'd7) ? 1 : 4;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_stimulus(logic [3:0] start, logic [3:0] op, logic [1:0] rs,
                                logic [1:0] rt, logic [1:0] rd);
    FSM_start = start;
    opcode    = op;
    rs_sel    = rs;
    rt_sel    = rt;
    rd_sel    = rd;
  endtask

  task automatic check_output(string name, logic [16:0] expv);
    logic [16:0] act;
    act = observed();
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s at %0t: actual=%05h expected=%05h", name, $time, act, expv);
    end
  endtask

  task automatic scramble_inputs();
    apply_stimulus(4'($urandom), 4'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
  endtask

  // Launch one instruction and compare every cycle until the block is back in IDLE.
  task automatic run_txn(logic [3:0] op, logic [1:0] rs, logic [1:0] rt, logic [1:0] rd);
    int len;
    len = txn_len(op);
    apply_stimulus(START, op, rs, rt, rd);
    tick();
    for (int k = 1; k <= len + 1; k++) begin
      check_output($sformatf("txn op=%h rs=%0d rt=%0d rd=%0d k=%0d", op, rs, rt, rd, k),
                   model(op, rs, rt, rd, k));
      if (k <= len) begin
        scramble_inputs();
        tick();
      end
    end
    apply_stimulus(4'd0, 4'd0, 2'd0, 2'd0, 2'd0);
  endtask

  typedef struct {
    string name;
    logic [3:0] start;
    logic [3:0] op;
    logic [1:0] rs, rt, rd;
    logic [16:0] expv;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int done_count;

    reset = 1'b1;
    apply_stimulus(4'd0, 4'd0, 2'd0, 2'd0, 2'd0);
    tick();
    tick();
    check_output("reset_state", 17'd0);
    reset = 1'b0;
    tick();
    check_output("idle_after_reset", 17'd0);

    // One row per cycle: inputs applied before the edge, outputs expected after it.
    vecs.push_back('{"add_c1", START, 4'h1, 2'd1, 2'd2, 2'd3, pk(4'b0010, 4'b0000, 1, 3'b000, 0, 0, 0, 1, 0)});
    vecs.push_back('{"add_c2", 4'h0, 4'hF, 2'd3, 2'd3, 2'd0, pk(4'b0100, 4'b0000, 0, 3'b000, 1, 0, 0, 1, 0)});
    vecs.push_back('{"add_c3", 4'h0, 4'h6, 2'd0, 2'd0, 2'd1, pk(4'b0000, 4'b1000, 0, 3'b000, 0, 1, 0, 1, 0)});
    vecs.push_back('{"add_c4", 4'h0, 4'h2, 2'd2, 2'd1, 2'd0, pk(4'b0000, 4'b0000, 0, 3'b000, 0, 0, 1, 1, 0)});
    vecs.push_back('{"add_c5", 4'h0, 4'h0, 2'd0, 2'd0, 2'd0, 17'd0});
    vecs.push_back('{"not_c1", START, 4'h3, 2'd2, 2'd1, 2'd0, pk(4'b0100, 4'b0000, 1, 3'b010, 0, 0, 0, 1, 0)});
    vecs.push_back('{"not_c2", 4'h0, 4'h1, 2'd1, 2'd3, 2'd2, pk(4'b0000, 4'b0000, 0, 3'b010, 1, 0, 0, 1, 0)});
    vecs.push_back('{"not_c3", 4'h0, 4'h1, 2'd1, 2'd3, 2'd2, pk(4'b0000, 4'b0001, 0, 3'b010, 0, 1, 0, 1, 0)});
    vecs.push_back('{"not_c4", 4'h0, 4'h0, 2'd0, 2'd0, 2'd0, pk(4'b0000, 4'b0000, 0, 3'b010, 0, 0, 1, 1, 0)});
    vecs.push_back('{"not_c5", 4'h0, 4'h0, 2'd0, 2'd0, 2'd0, 17'd0});
    vecs.push_back('{"illegal_c1", START, 4'hA, 2'd1, 2'd2, 2'd3, pk(4'b0000, 4'b0000, 0, 3'b000, 0, 0, 1, 1, 1)});
    vecs.push_back('{"illegal_c2", 4'h0, 4'hA, 2'd1, 2'd2, 2'd3, 17'd0});
    vecs.push_back('{"imm_code_c1", 4'h2, 4'h1, 2'd1, 2'd2, 2'd3, 17'd0});
    vecs.push_back('{"imm_code_c2", 4'h0, 4'h1, 2'd1, 2'd2, 2'd3, 17'd0});

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].start, vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd);
      tick();
      check_output(vecs[i].name, vecs[i].expv);
    end

    for (int op = 1; op <= 7; op++) run_txn(4'(op), 2'd1, 2'd2, 2'd3);
    run_txn(4'h0, 2'd0, 2'd0, 2'd0);
    run_txn(4'hF, 2'd3, 2'd3, 2'd3);
    run_txn(4'h2, 2'd2, 2'd2, 2'd2);

    for (int n = 0; n < 40; n++)
      run_txn(4'($urandom_range(0, 15)), 2'($urandom), 2'($urandom), 2'($urandom));

    // SUB with rd changed and FSM_start re-pulsed mid-operation.
    done_count = 0;
    apply_stimulus(START, 4'h2, 2'd0, 2'd1, 2'd3);
    tick();
    check_output("sub_chg_c1", model(4'h2, 2'd0, 2'd1, 2'd3, 1));
    if (DONE) done_count++;
    apply_stimulus(START, 4'h1, 2'd2, 2'd2, 2'd1);
    tick();
    check_output("sub_chg_c2", model(4'h2, 2'd0, 2'd1, 2'd3, 2));
    if (DONE) done_count++;
    apply_stimulus(4'h0, 4'h1, 2'd2, 2'd2, 2'd1);
    for (int k = 3; k <= 7; k++) begin
      tick();
      check_output($sformatf("sub_chg_c%0d", k), model(4'h2, 2'd0, 2'd1, 2'd3, k));
      if (DONE) done_count++;
    end
    checks++;
    if (done_count != 1) begin
      failures++;
      $display("[TB] FAIL sub_chg_done_count: actual=%0d expected=1", done_count);
    end

    // Reset asserted while in WRITE_BACK abandons the write without a DONE.
    apply_stimulus(START, 4'h1, 2'd1, 2'd2, 2'd3);
    tick();
    apply_stimulus(4'h0, 4'h1, 2'd1, 2'd2, 2'd3);
    tick();
    tick();
    check_output("rst_wb_reached", model(4'h1, 2'd1, 2'd2, 2'd3, 3));
    reset = 1'b1;
    tick();
    check_output("rst_wb_cleared", 17'd0);
    reset = 1'b0;
    tick();
    check_output("rst_wb_no_done", 17'd0);
    run_txn(4'h5, 2'd3, 2'd0, 2'd2);

    // FSM_start held high relaunches at the first edge after DONE_ST.
    apply_stimulus(START, 4'h6, 2'd0, 2'd1, 2'd2);
    tick();
    for (int k = 1; k <= 5; k++) begin
      check_output($sformatf("b2b_k%0d", k), model(4'h6, 2'd0, 2'd1, 2'd2, k));
      tick();
    end
    check_output("b2b_relaunch", model(4'h6, 2'd0, 2'd1, 2'd2, 1));
    apply_stimulus(4'h0, 4'h0, 2'd0, 2'd0, 2'd0);
    for (int k = 2; k <= 5; k++) begin
      tick();
      check_output($sformatf("b2b_second_k%0d", k), model(4'h6, 2'd0, 2'd1, 2'd2, k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
